ddr_read_prefetch: RTL and testbench
====================================

DDR_READ_PREFETCH -- requirements
Module: ddr_read_prefetch

Interface
REQ-001 SHALL have parameter IN_W, default 128, meaning the DDR-side data width in bits.
REQ-002 SHALL have parameter OUT_W, default 32, meaning the DAC-side data width; IN_W/OUT_W is a power of 2, >=1.
REQ-003 SHALL have parameter DEPTH, default 512, meaning the FIFO depth in IN_W entries (power of 2).
REQ-004 SHALL have parameter BURST_LEN, default 16, meaning the IN_W beats returned per DDR read request.
REQ-005 SHALL use one clock, clk, and a synchronous active-high reset, rst; ports are listed below.
- clk  in  1  sole clock.
- rst  in  1  sync active-high reset.
- ctrl_rd_en  in  1  streaming enable, level-sensitive.
- low_thresh  in  CW  refill watermark in entries; CW=log2(DEPTH)+1.
- start_thresh  in  CW  prefill level required before output starts.
- DDR_rd_req  out  1  burst request, held until acked.
- DDR_rd_ack  in  1  one-cycle acceptance of DDR_rd_req.
- wr_dataIn  in  IN_W  DDR read beat.
- wr_dataIn_valid  in  1  beat strobe.
- rd_dataout  out  OUT_W  output word.
- rd_dataout_valid  out  1  output word valid.
- rd_ready  in  1  consumer takes a word when valid&&ready.
- fifo_level  out  CW  stored entries.
- state_out  out  2  IDLE=0, PREFILL=1, STREAM=2, STOP=3.
- underrun  out  1  sticky; cleared by rst or on entry to PREFILL.
- overflow  out  1  sticky; cleared by rst only.

Function
REQ-006 SHALL track outstanding = beats requested but not received: +BURST_LEN on DDR_rd_ack, -1 per wr_dataIn_valid, with both applied in the same cycle when both occur.
REQ-007 SHALL raise DDR_rd_req, in PREFILL or STREAM only, when (fifo_level+outstanding) < max(low_thresh,start_thresh in PREFILL) and DEPTH-(fifo_level+outstanding) >= BURST_LEN.
REQ-008 SHALL hold DDR_rd_req until DDR_rd_ack, then deassert it for at least one cycle.
REQ-009 SHALL write wr_dataIn when wr_dataIn_valid and not full; writes while full are dropped and set overflow; a beat with outstanding==0 sets overflow but is still stored if space remains.
REQ-010 SHALL emit each entry as IN_W/OUT_W words, least-significant word first; an entry is popped when its last word is accepted.
REQ-011 SHALL update fifo_level one cycle after each write or pop; simultaneous write and pop leaves it unchanged.
REQ-012 SHALL implement the state machine: IDLE -> PREFILL when ctrl_rd_en=1; PREFILL -> STREAM when fifo_level >= start_thresh; PREFILL/STREAM -> STOP when ctrl_rd_en=0; STOP -> IDLE when outstanding==0 and the FIFO and output stage are flushed.
REQ-013 SHALL keep rd_dataout_valid=0 in IDLE, PREFILL and STOP; in STREAM it SHALL assert whenever a word is available, at most 3 cycles after the write into an empty FIFO.
REQ-014 SHALL hold rd_dataout stable while rd_dataout_valid=1 and rd_ready=0.
REQ-015 SHALL set underrun when, in STREAM, rd_ready=1 and rd_dataout_valid=0.
REQ-016 SHALL, in STOP, accept and discard in-flight beats without raising overflow, and issue no requests.
REQ-017 SHALL, if ctrl_rd_en reasserts during STOP, complete the flush to IDLE, then enter PREFILL the next cycle.
REQ-018 SHALL use fifo_level/outstanding arithmetic at CW+1 bits, so no wrap occurs at DEPTH.

Reset
REQ-019 SHALL, on rst, clear: state=IDLE, DDR_rd_req=0, rd_dataout_valid=0, rd_dataout=0, fifo_level=0, outstanding=0, underrun=0, overflow=0, and the sub-word index.
REQ-020 SHALL let rst mid-burst discard all stored and in-flight data; beats arriving after rst is released while in IDLE are dropped without setting overflow.

Verification (IN_W=128, OUT_W=32, DEPTH=64, BURST_LEN=8, low_thresh=16, start_thresh=32)
REQ-021 SHALL cover prefill: ctrl_rd_en=1, ack each request, return 8 beats per ack -> exactly 4 requests, valid stays 0 until level=32, then STREAM.
REQ-022 SHALL cover width order: write beat 0x00000003_00000002_00000001_00000000 with rd_ready=1 -> outputs 0,1,2,3 on consecutive cycles.
REQ-023 SHALL cover refill: STREAM with rd_ready=1 and level falling to 15 -> DDR_rd_req asserts; no request while level+outstanding > 56.
REQ-024 SHALL cover underrun: withhold beats in STREAM until the FIFO empties -> underrun=1 and remains set after refill.
REQ-025 SHALL cover stop: drop ctrl_rd_en with outstanding=8 -> no new requests, overflow stays 0, IDLE after the 8th beat plus flush.
REQ-026 SHALL cover overflow and reset: 9 unrequested beats in STREAM -> overflow=1; rst pulse -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/ddr_read_prefetch.sv
// ddr_read_prefetch: DDR burst prefetch FIFO that streams wide read beats out as narrow words
module ddr_read_prefetch #(
  parameter int IN_W = 128,
  parameter int OUT_W = 32,
  parameter int DEPTH = 512,
  parameter int BURST_LEN = 16,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ctrl_rd_en,
  input  logic [CW-1:0]   low_thresh,
  input  logic [CW-1:0]   start_thresh,
  output logic            DDR_rd_req,
  input  logic            DDR_rd_ack,
  input  logic [IN_W-1:0] wr_dataIn,
  input  logic            wr_dataIn_valid,
  output logic [OUT_W-1:0] rd_dataout,
  output logic            rd_dataout_valid,
  input  logic            rd_ready,
  output logic [CW-1:0]   fifo_level,
  output logic [1:0]      state_out,
  output logic            underrun,
  output logic            overflow
);
  localparam int AW = CW - 1;
  localparam int RATIO = IN_W / OUT_W;
  localparam int SW = RATIO > 1 ? $clog2(RATIO) : 1;
  typedef enum logic [1:0] {IDLE, PREFILL, STREAM, STOP} state_t;
  state_t state;
  logic [RATIO-1:0][OUT_W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [SW-1:0] sub;
  logic [CW:0] outstanding, sum;
  logic [CW-1:0] thr;
  logic active, accept, wr, ack, take, last, pop, need;
  assign state_out = state;
  always_comb begin
    active = state == PREFILL || state == STREAM;
    accept = wr_dataIn_valid && active;
    wr = accept && fifo_level != CW'(DEPTH);
    ack = DDR_rd_req && DDR_rd_ack;
    take = wr_dataIn_valid && outstanding != '0;
    rd_dataout_valid = state == STREAM && fifo_level != '0;
    rd_dataout = rd_dataout_valid ? mem[rptr][sub] : '0;
    last = sub == SW'(RATIO - 1);
    pop = rd_dataout_valid && rd_ready && last;
    thr = state == PREFILL && start_thresh > low_thresh ? start_thresh : low_thresh;
    sum = {1'b0, fifo_level} + outstanding;
    need = sum < {1'b0, thr} && sum <= (CW+1)'(DEPTH - BURST_LEN);
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= wr_dataIn;
    if (rst) begin
      state <= IDLE;
      DDR_rd_req <= 1'b0;
      wptr <= '0;
      rptr <= '0;
      sub <= '0;
      fifo_level <= '0;
      outstanding <= '0;
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (ctrl_rd_en) state <= PREFILL;
        PREFILL: state <= !ctrl_rd_en ? STOP : fifo_level >= start_thresh ? STREAM : PREFILL;
        STREAM: if (!ctrl_rd_en) state <= STOP;
        STOP: if (outstanding == '0 && fifo_level == '0) state <= IDLE;
      endcase
      // A held request drops on ack or when leaving the active states
      DDR_rd_req <= active && ctrl_rd_en && (DDR_rd_req ? !DDR_rd_ack : need);
      outstanding <= outstanding + (ack ? (CW+1)'(BURST_LEN) : '0) - (take ? (CW+1)'(1) : '0);
      overflow <= overflow | (accept && (fifo_level == CW'(DEPTH) || outstanding == '0));
      underrun <= state == IDLE && ctrl_rd_en ? 1'b0 : underrun | (state == STREAM && rd_ready && !rd_dataout_valid);
      if (state == STOP) begin
        rptr <= wptr;
        sub <= '0;
        fifo_level <= '0;
      end else begin
        if (wr) wptr <= wptr + 1'b1;
        if (pop) rptr <= rptr + 1'b1;
        if (rd_dataout_valid && rd_ready) sub <= last ? '0 : sub + 1'b1;
        fifo_level <= fifo_level + CW'(wr) - CW'(pop);
      end
    end
  end
endmodule

// File: tb/tb_ddr_read_prefetch.sv
// tb_ddr_read_prefetch: randomized directed phases checked against a word-queue reference model
module tb_ddr_read_prefetch;
  localparam int IN_W = 128, OUT_W = 32, DEPTH = 64, BURST_LEN = 8, CW = 7;
  localparam logic [IN_W-1:0] PAT = 128'h00000003_00000002_00000001_00000000;
  logic clk = 0, rst = 1, en = 0, ack_i = 0, beat_i = 0, rdy = 0;
  logic [CW-1:0] lt = 16, st = 32;
  logic [IN_W-1:0] din = '0;
  logic req, vld, unr, ovf;
  logic [OUT_W-1:0] dout;
  logic [CW-1:0] level;
  logic [1:0] state;
  int checks = 0, failures = 0;
  bit [31:0] q[$];
  int m_state = 0, m_out = 0;
  bit m_req = 0, m_unr = 0, m_ovf = 0;
  int pend = 0, extra = 0, acks = 0, rmode = 0;
  bit ack_en = 0, beat_en = 0, pat_next = 0;

  always #5 clk = ~clk;

  ddr_read_prefetch #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .BURST_LEN(BURST_LEN)) dut (
    .clk(clk), .rst(rst), .ctrl_rd_en(en), .low_thresh(lt), .start_thresh(st),
    .DDR_rd_req(req), .DDR_rd_ack(ack_i), .wr_dataIn(din), .wr_dataIn_valid(beat_i),
    .rd_dataout(dout), .rd_dataout_valid(vld), .rd_ready(rdy), .fifo_level(level),
    .state_out(state), .underrun(unr), .overflow(ovf));

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beats are only returned for acked bursts unless forced through extra
  task automatic drive();
    rdy = (rmode == 2) ? ($urandom_range(0, 1) == 1) : (rmode == 1);
    beat_i = 0;
    if (extra > 0) begin
      beat_i = 1;
      extra--;
    end else if (beat_en && pend > 0 && $urandom_range(0, 3) != 0) begin
      beat_i = 1;
      pend--;
    end
    din = pat_next ? PAT : {$urandom, $urandom, $urandom, $urandom};
    if (beat_i) pat_next = 0;
    ack_i = ack_en && req && $urandom_range(0, 1) == 1;
    if (ack_i) begin
      pend += BURST_LEN;
      acks++;
    end
  endtask

  task automatic model_step();
    int lvl, sum, thr, nstate;
    bit act, v, need, nreq;
    if (rst) begin
      q.delete();
      m_out = 0; m_state = 0; m_req = 0; m_unr = 0; m_ovf = 0;
      return;
    end
    lvl = (q.size() + 3) / 4;
    act = m_state == 1 || m_state == 2;
    v = m_state == 2 && q.size() > 0;
    sum = lvl + m_out;
    thr = (m_state == 1 && st > lt) ? int'(st) : int'(lt);
    need = sum < thr && DEPTH - sum >= BURST_LEN;
    nreq = act && en && (m_req ? !ack_i : need);
    nstate = m_state;
    case (m_state)
      0: if (en) nstate = 1;
      1: if (!en) nstate = 3; else if (lvl >= st) nstate = 2;
      2: if (!en) nstate = 3;
      default: if (m_out == 0 && lvl == 0) nstate = 0;
    endcase
    if (act && beat_i && (lvl == DEPTH || m_out == 0)) m_ovf = 1;
    if (m_state == 0 && en) m_unr = 0;
    else if (m_state == 2 && rdy && !v) m_unr = 1;
    if (m_state == 3) q.delete();
    else begin
      if (v && rdy) void'(q.pop_front());
      if (act && beat_i && lvl < DEPTH)
        for (int k = 0; k < 4; k++) q.push_back(din[32*k +: 32]);
    end
    if (beat_i && m_out > 0) m_out--;
    if (m_req && ack_i) m_out += BURST_LEN;
    m_req = nreq;
    m_state = nstate;
  endtask

  task automatic compare_all();
    chk("state", state, m_state);
    chk("level", level, (q.size() + 3) / 4);
    chk("valid", vld, m_state == 2 && q.size() > 0);
    if (m_state == 2 && q.size() > 0) chk("data", dout, q[0]);
    chk("req", req, m_req);
    chk("underrun", unr, m_unr);
    chk("overflow", ovf, m_ovf);
  endtask

  task automatic cycle();
    drive();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    int a0;
    @(negedge clk);
    cycle();
    cycle();
    rst = 0;
    chk("rst_dout", dout, 0);
    chk("rst_req", req, 0);
    // Prefill: exactly four bursts before streaming starts
    en = 1; ack_en = 1; beat_en = 1; pat_next = 1; acks = 0;
    for (int i = 0; i < 400 && state != 2; i++) cycle();
    chk("prefill_stream", state, 2);
    chk("prefill_reqs", acks, 4);
    chk("prefill_level", level, 32);
    // Word order within the first entry
    ack_en = 0; rmode = 1;
    for (int k = 0; k < 4; k++) begin
      chk("width_order", dout, k);
      cycle();
    end
    // Refill request once level reaches 15
    for (int i = 0; i < 400 && level != 15; i++) cycle();
    chk("refill_level", level, 15);
    cycle();
    chk("refill_req", req, 1);
    // High watermark exercises the DEPTH-BURST_LEN headroom limit
    lt = 62; ack_en = 1; beat_en = 1; rmode = 2;
    for (int i = 0; i < 300; i++) cycle();
    lt = 16;
    // Underrun: withhold beats until empty, then refill
    ack_en = 0; beat_en = 0; rmode = 1;
    for (int i = 0; i < 400 && level != 0; i++) cycle();
    chk("drain_level", level, 0);
    cycle();
    chk("underrun_set", unr, 1);
    ack_en = 1; beat_en = 1; rmode = 2;
    for (int i = 0; i < 150; i++) cycle();
    chk("underrun_sticky", unr, 1);
    for (int i = 0; i < 400; i++) cycle();
    // Stop with exactly one burst in flight
    ack_en = 0; beat_en = 1; rmode = 1;
    for (int i = 0; i < 600 && !(pend == 0 && req); i++) cycle();
    chk("stop_prep_req", req, 1);
    beat_en = 0; ack_en = 1; a0 = acks;
    for (int i = 0; i < 50 && acks == a0; i++) cycle();
    chk("stop_one_ack", acks - a0, 1);
    ack_en = 0; en = 0; beat_en = 1; rmode = 0;
    for (int i = 0; i < 100 && pend != 0; i++) cycle();
    chk("stop_state", state, 3);
    chk("stop_overflow", ovf, 0);
    en = 1;
    cycle();
    chk("stop_idle", state, 0);
    cycle();
    chk("restart_prefill", state, 1);
    // Overflow from unrequested beats, then saturation at DEPTH
    ack_en = 1; beat_en = 1; rmode = 0;
    for (int i = 0; i < 400 && state != 2; i++) cycle();
    chk("restream", state, 2);
    ack_en = 0;
    extra = 9;
    for (int i = 0; i < 9; i++) cycle();
    chk("overflow_set", ovf, 1);
    chk("overflow_level", level, 41);
    extra = 30;
    for (int i = 0; i < 30; i++) cycle();
    chk("full_level", level, 64);
    // Reset mid-stream clears everything
    en = 0; rst = 1; pend = 0;
    cycle();
    rst = 0;
    chk("rst2_state", state, 0);
    chk("rst2_req", req, 0);
    chk("rst2_valid", vld, 0);
    chk("rst2_dout", dout, 0);
    chk("rst2_level", level, 0);
    chk("rst2_underrun", unr, 0);
    chk("rst2_overflow", ovf, 0);
    extra = 3;
    for (int i = 0; i < 4; i++) cycle();
    chk("idle_beats_ovf", ovf, 0);
    chk("idle_beats_level", level, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
